// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Read-side master for a synchronous FIFO with registered dout and
//            write-priority arbitration. Pops bytes into a small circular
//            skid buffer and presents them on a valid/ready stream, keeping
//            a running count of delivered bytes.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_wr,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  byte_count
);

    localparam int c_ptr_w  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_occ_w  = $clog2(BUF_DEPTH + 1);
    localparam int c_free_w = c_occ_w + 1;

    localparam logic [c_ptr_w-1:0]  c_last_ptr = c_ptr_w'(BUF_DEPTH - 1);
    localparam logic [c_free_w-1:0] c_depth    = c_free_w'(BUF_DEPTH);

    logic [DATA_W-1:0]   r_buf [BUF_DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_occ_w-1:0]  r_occ;
    logic                r_pending;
    logic [CNT_W-1:0]    r_count;

    logic                w_pop;
    logic                w_acc;
    logic [c_free_w-1:0] w_free;

    // Circular pointer advance
    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign m_valid    = (r_occ != '0);
    assign m_data     = r_buf[r_head];
    assign byte_count = r_count;
    assign w_pop      = m_valid && m_ready;

    // Slots available for a new read: counts the byte already in flight and
    // credits a same-cycle pop, so the read strobe depends combinationally on
    // m_ready; this is what sustains one byte per cycle.
    assign w_free  = c_depth - c_free_w'(r_occ) - c_free_w'(r_pending)
                   + c_free_w'(w_pop);
    assign fifo_rd = !rst && en && !fifo_empty && (w_free >= c_free_w'(1));

    // The FIFO services an accepted write instead of a colliding read, so such
    // a read returns no data and is simply retried later.
    assign w_acc = fifo_rd && !(fifo_wr && !fifo_full);

    // One-cycle in-flight marker matching the FIFO's registered dout
    always_ff @(posedge clk) begin
        if (rst) r_pending <= 1'b0;
        else     r_pending <= w_acc;
    end

    // Capture the in-flight byte at the buffer tail
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
        end else if (r_pending) begin
            r_buf[r_tail] <= fifo_dout;
        end
    end

    // Head/tail pointers and occupancy; push and pop together cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (r_pending) r_tail <= f_next(r_tail);
            if (w_pop)     r_head <= f_next(r_head);
            case ({r_pending, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Delivered-byte counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)        r_count <= '0;
        else if (w_pop) r_count <= r_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side master for the team's 16-deep, 8-bit synchronous FIFO. It drives the FIFO's rd strobe, accounts for the FIFO's one-cycle registered dout and its write-priority arbitration, and re-presents the popped bytes on a valid/ready output stream through a small skid buffer. It also keeps a running count of delivered bytes. It sits between the FIFO and any downstream consumer, such as a serializer or checker.

Parameters:
DATA_W, 8, width of FIFO data and output stream data.
BUF_DEPTH, 2, output skid-buffer entries; must be 2 or more.
CNT_W, 16, width of the delivered-byte counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  permission to issue new FIFO reads.
fifo_empty  input  1  FIFO empty flag.
fifo_full  input  1  FIFO full flag.
fifo_wr  input  1  FIFO wr strobe, observed for collision detection.
fifo_dout  input  DATA_W  FIFO registered read data.
fifo_rd  output  1  FIFO read strobe.
m_valid  output  1  output stream data valid.
m_ready  input  1  downstream ready.
m_data  output  DATA_W  output stream data.
byte_count  output  CNT_W  number of completed output transfers.

Behaviour:
- Reset (rst=1 at an edge):
  - occupancy=0, pending=0, buffer cleared, byte_count=0.
  - m_valid=0 and m_data=0 after the edge.
  - fifo_rd=0 for the whole cycle rst is high.
- Output handshake:
  - pop = m_valid && m_ready.
  - m_valid = (occupancy != 0); m_data = buffer head entry.
  - Once m_valid is high, m_valid and m_data hold until pop.
- Free slots: free = BUF_DEPTH - occupancy - pending + pop.
  - The term includes the same-cycle pop, so fifo_rd has a combinational path from m_ready. This path is intentional and gives full throughput.
- Read strobe: fifo_rd = !rst && en && !fifo_empty && (free >= 1).
- Accepted read: acc = fifo_rd && !(fifo_wr && !fifo_full).
  - The FIFO services a write in preference to a read. A rd that collides with an accepted write is dropped by the FIFO and must not be counted.
  - The dropped byte is re-requested on a later cycle by the normal rule; no data is lost or duplicated.
- In-flight tracking:
  - pending <= acc at each edge; pending is 1 bit.
  - When pending=1, fifo_dout holds the popped byte this cycle and is written to the buffer tail at the edge.
- Latency: acc in cycle N gives m_valid=1 with that byte in cycle N+2, provided the buffer was empty.
- Throughput: 1 byte/cycle sustained while the FIFO is non-empty, there are no write collisions, and m_ready=1.
- Buffer:
  - Circular, with head/tail pointers mod BUF_DEPTH.
  - Push (pending) and pop in the same cycle leave occupancy unchanged.
  - Occupancy never exceeds BUF_DEPTH. Overflow is impossible by the free-slot rule.
- Counter: byte_count increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- en deasserted:
  - No new fifo_rd.
  - A pending byte is still captured.
  - Buffered bytes still drain on m_ready.
- fifo_empty asserted: fifo_rd=0 that cycle, with no other effect.
- Reset mid-operation:
  - Pending and buffered bytes are discarded; they are not delivered after reset.
  - The FIFO's own contents are not touched.
- Ordering: bytes leave m_data in exactly the FIFO pop order.

Test Plan:
- Basic drain: write 0x11,0x22,0x33 into the FIFO, then en=1, m_ready=1 -> m_data sequence 0x11,0x22,0x33 on consecutive cycles; first m_valid 2 cycles after the first fifo_rd; byte_count=3; fifo_rd=0 once fifo_empty=1.
- Backpressure: FIFO holds 0xA0..0xA5, m_ready=0 -> fifo_rd stops after 2 accepted reads; m_valid=1, m_data=0xA0 held stable. Then m_ready=1 -> 0xA0..0xA5 in order with no gaps and no duplicates.
- Write collision: FIFO holds 0x5A, and fifo_wr=1 with fifo_full=0 in the cycle fifo_rd=1 -> that read is not accepted; 0x5A is delivered exactly once, followed by the written byte; byte_count=2.
- en gating: deassert en the cycle after a fifo_rd -> the in-flight byte is still delivered; no further fifo_rd while en=0; reads resume when en=1.
- Reset mid-stream: rst=1 with 2 bytes buffered and 1 pending -> next cycle m_valid=0, byte_count=0, m_data=0. After release, remaining FIFO bytes are delivered in order and discarded bytes never appear.
- Counter wrap: CNT_W=4, deliver 17 bytes -> byte_count reads 15 then 0 then 1.
